johnson_decoder_monitor: RTL and testbench
==========================================

// Module: johnson_decoder_monitor
// PURPOSE
//  Receive-side companion to the Johnson counter. Samples a WIDTH-bit Johnson code
//  bus, decodes it to a binary state index and checks that the code is legal.
//  Checks that successive valid samples follow the Johnson sequence.
//  Provides lock indication and a saturating error count for self-check in benches and SoC.
// PARAMETERS
//  WIDTH      4  Johnson code width; sequence length 2*WIDTH; WIDTH>=2
//  LOCK_COUNT 2  consecutive correct transitions required to declare lock; >=1
//  ERR_CNT_W  8  width of saturating error counter
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             synchronous, active-high reset
//  in_valid     in   1             q_in is sampled on this edge when high
//  q_in         in   WIDTH         Johnson code from counter
//  index_out    out  IW            decoded index 0..2*WIDTH-1, IW=$clog2(2*WIDTH)
//  index_valid  out  1             1-cycle pulse: index_out updated from a legal code
//  code_err     out  1             1-cycle pulse: illegal code sampled
//  seq_err      out  1             1-cycle pulse: legal code, wrong successor, while LOCKED
//  locked       out  1             high while in LOCKED state
//  err_count    out  ERR_CNT_W     count of code_err+seq_err events, saturating
// BEHAVIOUR
//  Sequence (shift-left, insert ~msb): 0000,0001,0011,0111,1111,1110,1100,1000, then wraps.
//  Legal codes:
//   - msb=0: q_in = 2^k-1, k=0..WIDTH-1; index = k (popcount q_in).
//   - msb=1: ~q_in = 2^k-1, k=0..WIDTH-1; index = WIDTH+k.
//   - Any other pattern is illegal.
//  Expected successor of index i: (i+1) mod 2*WIDTH. 7->0 is correct for WIDTH=4.
//  A repeated index counts as a wrong successor.
//  Timing and idle behaviour:
//   - All outputs are registered; 1-cycle latency from sampling edge to outputs.
//   - in_valid low: no state change; index_out/locked/err_count hold; pulses low.
//  State machine (state, run counter, last index):
//   UNLOCKED (reset state)
//    - legal  -> ACQUIRE, run=0, last=index.
//    - illegal -> stay, code_err.
//   ACQUIRE
//    - legal correct -> run+1; if run+1==LOCK_COUNT -> LOCKED.
//    - legal wrong -> stay, run=0, no seq_err.
//    - illegal -> UNLOCKED, code_err.
//   LOCKED
//    - legal correct -> stay.
//    - legal wrong -> ACQUIRE, run=0, seq_err.
//    - illegal -> UNLOCKED, code_err.
//  Output updates:
//   - Every legal sample updates last/index_out and pulses index_valid.
//   - Illegal samples leave index_out unchanged.
//   - code_err and seq_err are never high together.
//  err_count:
//   - +1 per code_err or seq_err.
//   - Holds at 2^ERR_CNT_W-1.
//  Reset:
//   - rst has priority over in_valid, including mid-lock.
//   - Next cycle: state UNLOCKED, run=0, index_out=0, index_valid=0, code_err=0.
//   - Also: seq_err=0, locked=0, err_count=0.
// TESTING (WIDTH=4, LOCK_COUNT=2, ERR_CNT_W=8)
//  1 rst 2 cycles, then valid 0000,0001,0011 -> index_out 0,1,2 with index_valid
//    pulses; locked=1 one cycle after 0011 sampled; no errors.
//  2 locked, walk 0111..1000,0000 -> index 3..7,0; wrap gives no seq_err; locked stays 1.
//  3 locked, drive 0101 -> code_err pulse; err_count=1; locked=0.
//    index_out holds the previous value; no index_valid.
//  4 locked at index 2 (0011), drive 1111 -> seq_err pulse, index_out=4, err_count+1.
//    locked=0; 1110,1100 -> relock.
//  5 in_valid low 5 cycles mid-sequence, then next code -> outputs hold during gap;
//    no errors; sequence continues locked.
//  6 300 illegal samples -> err_count=255 and holds.
//    Assert rst while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/johnson_decoder_monitor_if.sv
// rtl/johnson_decoder_monitor_if.sv - sample/result bundle for the Johnson code monitor
// Purpose: groups the sampled Johnson code input and the decoded/status outputs.
// Ports (signals):
//   in_valid, q_in                       driven by the code source (master)
//   index_out, index_valid, code_err,
//   seq_err, locked, err_count           driven by the monitor (slave)
interface johnson_decoder_monitor_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int IW = $clog2(2 * WIDTH);

  logic                 in_valid;
  logic [WIDTH-1:0]     q_in;
  logic [IW-1:0]        index_out;
  logic                 index_valid;
  logic                 code_err;
  logic                 seq_err;
  logic                 locked;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, q_in,
    input  index_out, index_valid, code_err, seq_err, locked, err_count
  );

  modport slave (
    input  in_valid, q_in,
    output index_out, index_valid, code_err, seq_err, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder_monitor.sv
// rtl/johnson_decoder_monitor.sv - Johnson code decoder with sequence lock and error count
// Purpose: decodes a sampled Johnson code to its state index, flags illegal codes,
//   tracks whether successive samples follow the Johnson sequence and keeps a
//   saturating error count.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of johnson_decoder_monitor_if
//        in: in_valid, q_in
//        out: index_out, index_valid, code_err, seq_err, locked, err_count (all registered)
module johnson_decoder_monitor #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  johnson_decoder_monitor_if.slave      bus
);
  localparam int IW = $clog2(2 * WIDTH);
  localparam int RW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [RW-1:0]        run, run_n;
  logic [IW-1:0]        last, last_n;
  logic                 index_valid_n;
  logic                 code_err_n;
  logic                 seq_err_n;
  logic [ERR_CNT_W-1:0] err_count;

  function automatic logic [IW-1:0] ones(input logic [WIDTH-1:0] v);
    logic [IW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + IW'(v[i]);
    end
    return c;
  endfunction

  // Fold the upper half of the sequence onto the lower half: with msb set the
  // inverted code must be a run of ones from bit 0, same as the lower half.
  logic             msb;
  logic [WIDTH-1:0] folded;
  logic             legal;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    expect_idx;
  logic             correct;

  always_comb begin
    msb        = bus.q_in[WIDTH-1];
    folded     = msb ? ~bus.q_in : bus.q_in;
    // folded has msb 0 by construction; 2^k-1 iff no bit survives v & (v+1)
    legal      = ((folded & (folded + {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
    idx        = msb ? (IW'(WIDTH) + ones(folded)) : ones(folded);
    expect_idx = (last == IW'(2 * WIDTH - 1)) ? '0 : last + IW'(1);
    correct    = (idx == expect_idx);
  end

  always_comb begin
    state_n       = state;
    run_n         = run;
    last_n        = last;
    index_valid_n = 1'b0;
    code_err_n    = 1'b0;
    seq_err_n     = 1'b0;
    if (bus.in_valid) begin
      if (!legal) begin
        code_err_n = 1'b1;
        state_n    = UNLOCKED;
        run_n      = '0;
      end else begin
        last_n        = idx;
        index_valid_n = 1'b1;
        unique case (state)
          UNLOCKED: begin
            state_n = ACQUIRE;
            run_n   = '0;
          end
          ACQUIRE: begin
            if (correct) begin
              if (run + RW'(1) == RW'(LOCK_COUNT)) begin
                state_n = LOCKED;
                run_n   = '0;
              end else begin
                run_n = run + RW'(1);
              end
            end else begin
              run_n = '0;
            end
          end
          LOCKED: begin
            if (!correct) begin
              state_n   = ACQUIRE;
              run_n     = '0;
              seq_err_n = 1'b1;
            end
          end
          default: begin
            state_n = UNLOCKED;
            run_n   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= UNLOCKED;
      run             <= '0;
      last            <= '0;
      bus.index_valid <= 1'b0;
      bus.code_err    <= 1'b0;
      bus.seq_err     <= 1'b0;
      bus.locked      <= 1'b0;
      err_count       <= '0;
    end else begin
      state           <= state_n;
      run             <= run_n;
      last            <= last_n;
      bus.index_valid <= index_valid_n;
      bus.code_err    <= code_err_n;
      bus.seq_err     <= seq_err_n;
      bus.locked      <= (state_n == LOCKED);
      if ((code_err_n || seq_err_n) && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.index_out = last;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_johnson_decoder_monitor.sv
// tb/tb_johnson_decoder_monitor.sv - directed vector bench for johnson_decoder_monitor
module tb_johnson_decoder_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  johnson_decoder_monitor_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

  johnson_decoder_monitor #(.WIDTH(4), .LOCK_COUNT(2), .ERR_CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       valid;
    logic [3:0] q;
    logic [2:0] idx;
    logic       iv;
    logic       ce;
    logic       se;
    logic       lk;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [3:0] q, input logic [2:0] idx,
                     input logic iv, input logic ce, input logic se, input logic lk,
                     input logic [7:0] ec);
    vec_t t;
    t.valid = v; t.q = q; t.idx = idx; t.iv = iv; t.ce = ce; t.se = se; t.lk = lk; t.ec = ec;
    vecs.push_back(t);
  endtask

  // Drive one sample, then look at the registered outputs just after the edge.
  task automatic step(input logic v, input logic [3:0] q);
    bus.in_valid = v;
    bus.q_in     = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, " index_out"},   int'(bus.index_out),   int'(e.idx));
    chk({tag, " index_valid"}, int'(bus.index_valid), int'(e.iv));
    chk({tag, " code_err"},    int'(bus.code_err),    int'(e.ce));
    chk({tag, " seq_err"},     int'(bus.seq_err),     int'(e.se));
    chk({tag, " locked"},      int'(bus.locked),      int'(e.lk));
    chk({tag, " err_count"},   int'(bus.err_count),   int'(e.ec));
  endtask

  initial begin
    vec_t z;
    // acquire and lock
    add(1, 4'b0000, 0, 1, 0, 0, 0, 0);
    add(1, 4'b0001, 1, 1, 0, 0, 0, 0);
    add(1, 4'b0011, 2, 1, 0, 0, 1, 0);
    // walk through upper half and wrap
    add(1, 4'b0111, 3, 1, 0, 0, 1, 0);
    add(1, 4'b1111, 4, 1, 0, 0, 1, 0);
    add(1, 4'b1110, 5, 1, 0, 0, 1, 0);
    add(1, 4'b1100, 6, 1, 0, 0, 1, 0);
    add(1, 4'b1000, 7, 1, 0, 0, 1, 0);
    add(1, 4'b0000, 0, 1, 0, 0, 1, 0);
    add(1, 4'b0001, 1, 1, 0, 0, 1, 0);
    // illegal code while locked
    add(1, 4'b0101, 1, 0, 1, 0, 0, 1);
    add(1, 4'b0011, 2, 1, 0, 0, 0, 1);
    add(1, 4'b0111, 3, 1, 0, 0, 0, 1);
    add(1, 4'b1111, 4, 1, 0, 0, 1, 1);
    add(1, 4'b1110, 5, 1, 0, 0, 1, 1);
    add(1, 4'b1100, 6, 1, 0, 0, 1, 1);
    add(1, 4'b1000, 7, 1, 0, 0, 1, 1);
    add(1, 4'b0000, 0, 1, 0, 0, 1, 1);
    add(1, 4'b0001, 1, 1, 0, 0, 1, 1);
    add(1, 4'b0011, 2, 1, 0, 0, 1, 1);
    // skip ahead from 2 to 4 while locked, then relock
    add(1, 4'b1111, 4, 1, 0, 1, 0, 2);
    add(1, 4'b1110, 5, 1, 0, 0, 0, 2);
    add(1, 4'b1100, 6, 1, 0, 0, 1, 2);
    // idle gap: q_in ignored, outputs hold
    add(0, 4'b0101, 6, 0, 0, 0, 1, 2);
    add(0, 4'b0000, 6, 0, 0, 0, 1, 2);
    add(0, 4'b1111, 6, 0, 0, 0, 1, 2);
    add(0, 4'b1010, 6, 0, 0, 0, 1, 2);
    add(0, 4'b0111, 6, 0, 0, 0, 1, 2);
    add(1, 4'b1000, 7, 1, 0, 0, 1, 2);
    add(1, 4'b0000, 0, 1, 0, 0, 1, 2);
    // repeated index: seq_err while locked, silent restart while acquiring
    add(1, 4'b0000, 0, 1, 0, 1, 0, 3);
    add(1, 4'b0000, 0, 1, 0, 0, 0, 3);
    add(1, 4'b0001, 1, 1, 0, 0, 0, 3);
    add(1, 4'b0011, 2, 1, 0, 0, 1, 3);

    bus.in_valid = 1'b0;
    bus.q_in     = 4'b0000;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    z.idx = 0; z.iv = 0; z.ce = 0; z.se = 0; z.lk = 0; z.ec = 0;
    chk_all("reset", z);

    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].q);
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // saturation: err_count is 3 here, 252 illegal samples reach 255
    for (int i = 0; i < 252; i++) step(1'b1, 4'b1001);
    chk("sat reach err_count", int'(bus.err_count), 255);
    chk("sat reach code_err",  int'(bus.code_err), 1);
    chk("sat reach index_out", int'(bus.index_out), 2);
    for (int i = 0; i < 48; i++) step(1'b1, 4'b0110);
    chk("sat hold err_count", int'(bus.err_count), 255);
    chk("sat hold code_err",  int'(bus.code_err), 1);
    chk("sat hold locked",    int'(bus.locked), 0);

    // relock, then reset with in_valid high wins
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b1111);
    chk("relock locked",    int'(bus.locked), 1);
    chk("relock index_out", int'(bus.index_out), 4);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.q_in     = 4'b1110;
    @(posedge clk);
    #1;
    chk_all("rst mid-lock", z);
    rst = 1'b0;
    step(1'b1, 4'b1010);
    chk("post rst code_err",  int'(bus.code_err), 1);
    chk("post rst err_count", int'(bus.err_count), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
